// File: rtl/demux_l2_4f.sv
`default_nettype none
// ============================================================================
//  Module      : demux_l2_4f
//  Description : Single-clock 1:4 lane demultiplexer. Splits the serialized
//                word stream from the two-level 4:1 mux stage back into four
//                lanes. Completed frames go into a 2-entry frame buffer with
//                a valid/ready handshake toward the consumer.
//  Ports       : clk_4f       - clock, one serialized word per rising edge
//                reset        - synchronous active-high reset
//                data_in      - serialized word, [DATA_W] valid, [DATA_W-1:0] payload
//                frame_ready  - consumer accepts the head frame
//                data0..data3 - head frame lane words (zero when empty)
//                frame_valid  - frame buffer not empty
//                lane         - current lane counter
//                overflow     - sticky, a frame was dropped on a full buffer
//                frame_count  - accepted frames, modulo 256
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_l2_4f #(
    parameter int DATA_W     = 8,
    parameter int LANE_START = 0
) (
    input  logic              clk_4f,
    input  logic              reset,
    input  logic [DATA_W:0]   data_in,
    input  logic              frame_ready,
    output logic [DATA_W:0]   data0,
    output logic [DATA_W:0]   data1,
    output logic [DATA_W:0]   data2,
    output logic [DATA_W:0]   data3,
    output logic              frame_valid,
    output logic [1:0]        lane,
    output logic              overflow,
    output logic [7:0]        frame_count
);

    localparam int         c_WORD_W     = DATA_W + 1;
    localparam int         c_FRAME_W    = 4 * c_WORD_W;
    localparam logic [1:0] c_LANE_START = 2'(LANE_START);

    // State
    logic [1:0]                      r_lane_q;
    logic [2:0][c_WORD_W-1:0]        r_asm_q;
    logic [1:0][c_FRAME_W-1:0]       r_mem_q;
    logic                            r_wptr_q;
    logic                            r_rptr_q;
    logic [1:0]                      r_occ_q;
    logic                            r_overflow_q;
    logic [7:0]                      r_frame_count_q;

    // Next state
    logic [1:0]                      w_lane_d;
    logic [2:0][c_WORD_W-1:0]        w_asm_d;
    logic [1:0][c_FRAME_W-1:0]       w_mem_d;
    logic                            w_wptr_d;
    logic                            w_rptr_d;
    logic [1:0]                      w_occ_d;
    logic                            w_overflow_d;
    logic [7:0]                      w_frame_count_d;

    // Datapath helpers
    logic [c_FRAME_W-1:0]            w_frame;
    logic                            w_any_valid;
    logic                            w_push_req;
    logic                            w_push;
    logic                            w_pop;
    logic [c_FRAME_W-1:0]            w_head;

    always_comb begin
        w_lane_d        = r_lane_q + 2'd1;
        w_asm_d         = r_asm_q;
        w_mem_d         = r_mem_q;
        w_wptr_d        = r_wptr_q;
        w_rptr_d        = r_rptr_q;
        w_occ_d         = r_occ_q;
        w_overflow_d    = r_overflow_q;
        w_frame_count_d = r_frame_count_q;

        // Lane 0 word sits in the most significant slot of the frame.
        w_frame     = {r_asm_q[0], r_asm_q[1], r_asm_q[2], data_in};
        w_any_valid = r_asm_q[0][DATA_W] | r_asm_q[1][DATA_W] |
                      r_asm_q[2][DATA_W] | data_in[DATA_W];

        w_pop      = (r_occ_q != 2'd0) && frame_ready;
        w_push_req = (r_lane_q == 2'd3) && w_any_valid;
        // A full buffer still accepts when the head leaves on the same edge.
        w_push     = w_push_req && ((r_occ_q != 2'd2) || w_pop);

        case (r_lane_q)
            2'd0:    w_asm_d[0] = data_in;
            2'd1:    w_asm_d[1] = data_in;
            2'd2:    w_asm_d[2] = data_in;
            default: ;
        endcase

        if (w_push) begin
            w_mem_d[r_wptr_q] = w_frame;
            w_wptr_d          = ~r_wptr_q;
            w_frame_count_d   = r_frame_count_q + 8'd1;
        end

        if (w_push_req && !w_push) begin
            w_overflow_d = 1'b1;
        end

        if (w_pop) begin
            w_rptr_d = ~r_rptr_q;
        end

        case ({w_push, w_pop})
            2'b10:   w_occ_d = r_occ_q + 2'd1;
            2'b01:   w_occ_d = r_occ_q - 2'd1;
            default: w_occ_d = r_occ_q;
        endcase
    end

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            r_lane_q        <= c_LANE_START;
            r_asm_q         <= '0;
            r_mem_q         <= '0;
            r_wptr_q        <= 1'b0;
            r_rptr_q        <= 1'b0;
            r_occ_q         <= 2'd0;
            r_overflow_q    <= 1'b0;
            r_frame_count_q <= 8'd0;
        end else begin
            r_lane_q        <= w_lane_d;
            r_asm_q         <= w_asm_d;
            r_mem_q         <= w_mem_d;
            r_wptr_q        <= w_wptr_d;
            r_rptr_q        <= w_rptr_d;
            r_occ_q         <= w_occ_d;
            r_overflow_q    <= w_overflow_d;
            r_frame_count_q <= w_frame_count_d;
        end
    end

    // Head entry is read straight from storage; masked to zero when empty.
    assign frame_valid = (r_occ_q != 2'd0);
    assign w_head      = frame_valid ? r_mem_q[r_rptr_q] : '0;

    assign data0       = w_head[4*c_WORD_W-1 -: c_WORD_W];
    assign data1       = w_head[3*c_WORD_W-1 -: c_WORD_W];
    assign data2       = w_head[2*c_WORD_W-1 -: c_WORD_W];
    assign data3       = w_head[1*c_WORD_W-1 -: c_WORD_W];

    assign lane        = r_lane_q;
    assign overflow    = r_overflow_q;
    assign frame_count = r_frame_count_q;

endmodule
`default_nettype wire

// File: tb/tb_demux_l2_4f.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux_l2_4f
//  Description : Self-checking bench for demux_l2_4f. Directed scenarios
//                followed by randomized traffic, all compared every cycle
//                against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_l2_4f;

    localparam int c_DW         = 8;
    localparam int c_LANE_START = 0;

    logic              clk_4f = 1'b0;
    logic              reset  = 1'b1;
    logic [c_DW:0]     data_in = '0;
    logic              frame_ready = 1'b0;
    logic [c_DW:0]     data0, data1, data2, data3;
    logic              frame_valid;
    logic [1:0]        lane;
    logic              overflow;
    logic [7:0]        frame_count;

    demux_l2_4f #(.DATA_W(c_DW), .LANE_START(c_LANE_START)) u_dut (
        .clk_4f      (clk_4f),
        .reset       (reset),
        .data_in     (data_in),
        .frame_ready (frame_ready),
        .data0       (data0),
        .data1       (data1),
        .data2       (data2),
        .data3       (data3),
        .frame_valid (frame_valid),
        .lane        (lane),
        .overflow    (overflow),
        .frame_count (frame_count)
    );

    always #5 clk_4f = ~clk_4f;

    // Reference model state
    logic [35:0]  m_q[$];
    logic [8:0]   m_asm[3];
    int           m_lane;
    logic         m_ovf;
    logic [7:0]   m_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    task automatic model_step(input logic [8:0] din, input logic rdy, input logic rst);
        logic        pop;
        logic        accept;
        logic [35:0] frame;
        accept = 1'b0;
        frame  = '0;
        if (rst) begin
            m_lane = c_LANE_START;
            m_q.delete();
            for (int i = 0; i < 3; i++) m_asm[i] = '0;
            m_ovf = 1'b0;
            m_cnt = 8'd0;
        end else begin
            pop = (m_q.size() > 0) && rdy;
            if (m_lane < 3) begin
                m_asm[m_lane] = din;
            end else if (m_asm[0][8] || m_asm[1][8] || m_asm[2][8] || din[8]) begin
                frame = {m_asm[0], m_asm[1], m_asm[2], din};
                if (m_q.size() < 2 || pop) begin
                    accept = 1'b1;
                    m_cnt  = m_cnt + 8'd1;
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (pop) void'(m_q.pop_front());
            if (accept) m_q.push_back(frame);
            m_lane = (m_lane + 1) % 4;
        end
    endtask

    task automatic compare_all();
        logic [35:0] head;
        head = (m_q.size() > 0) ? m_q[0] : 36'd0;
        check("lane",        64'(lane),        64'(m_lane));
        check("frame_valid", 64'(frame_valid), 64'(m_q.size() > 0));
        check("data0",       64'(data0),       64'(head[35:27]));
        check("data1",       64'(data1),       64'(head[26:18]));
        check("data2",       64'(data2),       64'(head[17:9]));
        check("data3",       64'(data3),       64'(head[8:0]));
        check("overflow",    64'(overflow),    64'(m_ovf));
        check("frame_count", 64'(frame_count), 64'(m_cnt));
    endtask

    task automatic tick(input logic [8:0] din, input logic rdy, input logic rst);
        data_in     = din;
        frame_ready = rdy;
        reset       = rst;
        @(posedge clk_4f);
        model_step(din, rdy, rst);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        tick(9'h000, 1'b0, 1'b1);
        tick(9'h000, 1'b0, 1'b1);
    endtask

    task automatic send_frame(input logic [8:0] w0, input logic [8:0] w1,
                              input logic [8:0] w2, input logic [8:0] w3,
                              input logic rdy);
        tick(w0, rdy, 1'b0);
        tick(w1, rdy, 1'b0);
        tick(w2, rdy, 1'b0);
        tick(w3, rdy, 1'b0);
    endtask

    initial begin
        // 1. Reset and lane alignment
        do_reset();
        check("rst_lane",  64'(lane), 64'd0);
        check("rst_valid", 64'(frame_valid), 64'd0);
        check("rst_data0", 64'(data0), 64'd0);
        check("rst_count", 64'(frame_count), 64'd0);
        for (int i = 1; i <= 5; i++) begin
            tick(9'h000, 1'b0, 1'b0);
            check("lane_seq", 64'(lane), 64'(i % 4));
        end

        // 2. Basic frame
        do_reset();
        send_frame(9'h1A1, 9'h1A2, 9'h1A3, 9'h1A4, 1'b1);
        check("basic_valid", 64'(frame_valid), 64'd1);
        check("basic_d0",    64'(data0), 64'h1A1);
        check("basic_d3",    64'(data3), 64'h1A4);
        check("basic_count", 64'(frame_count), 64'd1);
        tick(9'h000, 1'b1, 1'b0);
        check("basic_once",  64'(frame_valid), 64'd0);

        // 3. Valid filtering
        do_reset();
        send_frame(9'h000, 9'h055, 9'h0AA, 9'h0FF, 1'b0);
        check("filt_valid", 64'(frame_valid), 64'd0);
        check("filt_count", 64'(frame_count), 64'd0);
        send_frame(9'h1FF, 9'h000, 9'h000, 9'h000, 1'b0);
        check("filt2_d0",    64'(data0), 64'h1FF);
        check("filt2_d1",    64'(data1), 64'h000);
        check("filt2_count", 64'(frame_count), 64'd1);

        // 4. Backpressure and overflow
        do_reset();
        send_frame(9'h101, 9'h102, 9'h103, 9'h104, 1'b0);
        send_frame(9'h111, 9'h112, 9'h113, 9'h114, 1'b0);
        send_frame(9'h121, 9'h122, 9'h123, 9'h124, 1'b0);
        check("ovf_flag",  64'(overflow), 64'd1);
        check("ovf_count", 64'(frame_count), 64'd2);
        check("ovf_head",  64'(data0), 64'h101);
        tick(9'h000, 1'b1, 1'b0);
        check("ovf_f2",    64'(data0), 64'h111);
        tick(9'h000, 1'b1, 1'b0);
        check("ovf_empty", 64'(frame_valid), 64'd0);
        check("ovf_held",  64'(overflow), 64'd1);

        // 5. Push and pop together at full
        do_reset();
        send_frame(9'h101, 9'h102, 9'h103, 9'h104, 1'b0);
        send_frame(9'h111, 9'h112, 9'h113, 9'h114, 1'b0);
        tick(9'h121, 1'b0, 1'b0);
        tick(9'h122, 1'b0, 1'b0);
        tick(9'h123, 1'b0, 1'b0);
        tick(9'h124, 1'b1, 1'b0);
        check("pp_ovf",   64'(overflow), 64'd0);
        check("pp_count", 64'(frame_count), 64'd3);
        check("pp_f2",    64'(data0), 64'h111);
        tick(9'h000, 1'b1, 1'b0);
        check("pp_f3",    64'(data3), 64'h124);
        tick(9'h000, 1'b1, 1'b0);
        check("pp_empty", 64'(frame_valid), 64'd0);

        // 6. Reset mid-frame
        do_reset();
        tick(9'h1C1, 1'b0, 1'b0);
        tick(9'h1C2, 1'b0, 1'b0);
        tick(9'h000, 1'b0, 1'b1);
        send_frame(9'h1D1, 9'h1D2, 9'h1D3, 9'h1D4, 1'b0);
        check("mid_d0",    64'(data0), 64'h1D1);
        check("mid_d1",    64'(data1), 64'h1D2);
        check("mid_count", 64'(frame_count), 64'd1);

        // frame_count wrap: 260 accepted frames
        do_reset();
        for (int f = 0; f < 260; f++) begin
            send_frame({1'b1, 8'($urandom)}, 9'(f), 9'(f), 9'(f), 1'b1);
        end
        check("wrap_count", 64'(frame_count), 64'd4);

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 1200; c++) begin
            logic [8:0] din;
            din = {($urandom_range(0, 3) == 0), 8'($urandom)};
            tick(din, 1'($urandom_range(0, 1)), ($urandom_range(0, 149) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/demux_l2_4f.md
Name: demux_l2_4f

Overview:
- Downstream partner of the two-level 4:1 mux stage (muxes / muxesEstructural).
- Takes the serialized 9-bit lane stream produced at clk_4f rate and splits it back into four 9-bit lanes, data0..data3.
- Runs on a single clock, using an internal lane counter in place of derived clk_2f/clk_f clocks.
- Assembled frames enter a 2-entry frame buffer with a valid/ready handshake toward the consumer.

Parameters:
- DATA_W, 8, payload width; each word is DATA_W+1 bits wide, with bit DATA_W as the valid flag.
- LANE_START, 0, lane counter value loaded on reset; aligns the counter to the mux pipeline latency (range 0..3).

Ports:
- clk_4f  input  1  single clock; one serialized word per rising edge.
- reset  input  1  synchronous, active-high reset; sampled on the rising edge of clk_4f.
- data_in  input  DATA_W+1  serialized word from the mux stage: [DATA_W] is valid, [DATA_W-1:0] is payload.
- frame_ready  input  1  consumer accepts the head frame when frame_valid is also high.
- data0  output  DATA_W+1  head frame, lane 0 word.
- data1  output  DATA_W+1  head frame, lane 1 word.
- data2  output  DATA_W+1  head frame, lane 2 word.
- data3  output  DATA_W+1  head frame, lane 3 word.
- frame_valid  output  1  frame buffer not empty.
- lane  output  2  current lane counter value.
- overflow  output  1  sticky flag: a frame was dropped because the buffer was full.
- frame_count  output  8  number of frames accepted into the buffer, modulo 256.

Behaviour:
- Reset (reset=1 at an edge):
  - lane=LANE_START, buffer emptied, assembly registers = 0.
  - frame_valid=0, data0..3=0, overflow=0, frame_count=0.
  - Any partial frame in progress is discarded.
- Lane counter:
  - Increments modulo 4 on every edge while reset=0 (3 wraps to 0).
  - Advances regardless of data_in valid, because the mux emits a word every clk_4f cycle.
- Lane ordering is fixed: the word sampled while lane=k belongs to lane k. The mux emits data0 first.
- Assembly:
  - When lane is 0, 1 or 2, data_in is stored in asm[lane].
  - When lane=3, the frame {asm0, asm1, asm2, data_in} is complete and a push is attempted on that same edge.
- Push filtering:
  - A frame whose four valid bits are all 0 is discarded: no push, no count, no overflow.
  - A frame with any valid bit set is pushed unchanged, including its invalid lanes.
- Frame buffer:
  - 2-entry FIFO, in-order delivery.
  - Pop occurs when frame_valid=1 and frame_ready=1 at an edge.
  - frame_valid = not empty.
  - data0..3 show the head entry, combinationally from buffer storage; they are forced to 0 when empty.
- Latency: the lane-3 word sampled at edge N into an empty buffer gives frame_valid=1 and head data visible after edge N, i.e. 1 cycle.
- Full buffer:
  - Push with a simultaneous pop: both occur, occupancy stays 2, and the frame is accepted.
  - Push with no pop: the new frame is dropped, overflow is set to 1 and held until reset, and frame_count is unchanged.
- Pop when empty: ignored; frame_ready is a don't-care while frame_valid=0.
- frame_count: increments by 1 per accepted push and wraps 255 -> 0.
- Reset has priority over push and pop in the same cycle.
- Output registers: all state is registered. The only combinational paths to outputs are the zero-forcing of data0..3 and frame_valid.

Test Plan:
1. Reset and alignment:
   - Stimulus: reset=1 for 2 edges, then release.
   - Required: outputs all 0 and lane=0; lane then reads 1,2,3,0,1 on successive edges.
2. Basic frame:
   - Stimulus: frame_ready=1; data_in = 9'h1A1, 9'h1A2, 9'h1A3, 9'h1A4 on lanes 0..3.
   - Required: the cycle after the 4th word, frame_valid=1 for exactly 1 cycle with data0..3 = 1A1/1A2/1A3/1A4, and frame_count=1.
3. Valid filtering:
   - Stimulus: frame 000/055/0AA/0FF, then frame 1FF/000/000/000.
   - Required: the first frame produces no frame_valid and frame_count stays 0. The second frame is pushed with data0=1FF and data1..3=000, and frame_count=1.
4. Backpressure and overflow:
   - Stimulus: frame_ready=0; send F1=101..104, F2=111..114, F3=121..124.
   - Required: after F3, overflow=1 and frame_count=2. Then frame_ready=1 delivers F1 then F2 on consecutive cycles, frame_valid then drops, and overflow stays 1.
5. Simultaneous push and pop at full:
   - Stimulus: with F1 and F2 buffered, raise frame_ready exactly on F3's lane-3 edge.
   - Required: F1 is popped and F3 is accepted, overflow=0, and frame_count=3; the bench then sees F2 then F3 in order.
6. Reset mid-frame:
   - Stimulus: send 1C1, 1C2, assert reset for 1 edge, then send 1D1..1D4.
   - Required: no frame containing 1C1/1C2 ever appears; the next frame is 1D1..1D4 with frame_count=1.
